ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 165 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX-stage ALU feeding the EX/MEM pipeline register.
// Single-cycle ops (ADD, SUB, funct3-decoded) load EX/MEM on the next edge.
// Optional feature macro EX_MUL_EN: when defined, alu_op=11 runs a 32-step
// shift-add multiplier FSM (IDLE/BUSY/DONE) that stalls upstream while busy.
// When EX_MUL_EN is undefined, alu_op=11 executes as ADD and stall is tied low.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_read_data1,
  input  logic [31:0] ex_read_data2,
  input  logic [31:0] ex_imm_ext,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_alu_src,
  input  logic [1:0]  ex_alu_op,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_flush,
  output logic        stall,
  output logic        mem_valid,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write
);

  logic [31:0] opB;
  logic [31:0] aluResult;
  logic [31:0] finalResult;
  logic        loadValid;

  logic        memValid_q;
  logic [31:0] memAluResult_q;
  logic [31:0] memStoreData_q;
  logic [4:0]  memRd_q;
  logic        memRegWrite_q;

  assign opB = ex_alu_src ? ex_imm_ext : ex_read_data2;

  // Single-cycle ALU; alu_op=11 falls back to ADD when no multiplier result is committing
  always_comb begin
    aluResult = ex_read_data1 + opB;
    case (ex_alu_op)
      2'b00: aluResult = ex_read_data1 + opB;
      2'b01: aluResult = ex_read_data1 - opB;
      2'b10: begin
        case (ex_funct3)
          3'b000:  aluResult = ex_read_data1 + opB;
          3'b001:  aluResult = ex_read_data1 << opB[4:0];
          3'b010:  aluResult = {31'd0, ($signed(ex_read_data1) < $signed(opB))};
          3'b011:  aluResult = {31'd0, (ex_read_data1 < opB)};
          3'b100:  aluResult = ex_read_data1 ^ opB;
          3'b101:  aluResult = ex_read_data1 >> opB[4:0];
          3'b110:  aluResult = ex_read_data1 | opB;
          default: aluResult = ex_read_data1 & opB;
        endcase
      end
      default: aluResult = ex_read_data1 + opB;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;

  mulState_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;
  logic        mulStart;
  logic        mulCommit;

  // A multiply may only begin from IDLE; reset and flush both suppress the start
  assign mulStart  = !reset && (state_q == IDLE) && ex_valid && !ex_flush && (ex_alu_op == 2'b11);
  assign mulCommit = (state_q == DONE) && (ex_alu_op == 2'b11);

  // Multiplier next-state, shift-add datapath and stall generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mulStart) begin
          stall    = 1'b1;
          mcand_d  = ex_read_data1;
          mplier_d = opB;
          prod_d   = 32'd0;
          cnt_d    = 5'd0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (ex_flush) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier state registers; reset discards any partial product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      prod_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign finalResult = mulCommit ? prod_q : aluResult;
`else
  assign stall       = 1'b0;
  assign finalResult = aluResult;
`endif

  assign loadValid = ex_valid && !ex_flush && !stall;

  // EX/MEM register: valid entries load everything, bubbles clear valid/writeback and hold the rest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memValid_q     <= 1'b0;
      memAluResult_q <= 32'd0;
      memStoreData_q <= 32'd0;
      memRd_q        <= 5'd0;
      memRegWrite_q  <= 1'b0;
    end else begin
      memValid_q    <= loadValid;
      memRegWrite_q <= loadValid && ex_reg_write && (ex_rd != 5'd0);
      if (loadValid) begin
        memAluResult_q <= finalResult;
        memStoreData_q <= ex_read_data2;
        memRd_q        <= ex_rd;
      end
    end
  end

  assign mem_valid      = memValid_q;
  assign mem_alu_result = memAluResult_q;
  assign mem_store_data = memStoreData_q;
  assign mem_rd         = memRd_q;
  assign mem_reg_write  = memRegWrite_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of ex_mem_stage against a
// behavioural model of the EX/MEM stage. Multiplier scenarios are exercised
// when EX_MUL_EN is defined; otherwise alu_op=11 is expected to act as ADD.
module tb_ex_mem_stage;

`ifdef EX_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_read_data1;
  logic [31:0] ex_read_data2;
  logic [31:0] ex_imm_ext;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_alu_src;
  logic [1:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_flush;
  logic        stall;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;

  int checks = 0;
  int failures = 0;

  logic [31:0] expResult;
  logic [31:0] expStore;
  logic [4:0]  expRd;
  logic        expValid;
  logic        expRw;

  ex_mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_read_data1  (ex_read_data1),
    .ex_read_data2  (ex_read_data2),
    .ex_imm_ext     (ex_imm_ext),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_alu_src     (ex_alu_src),
    .ex_alu_op      (ex_alu_op),
    .ex_funct3      (ex_funct3),
    .ex_flush       (ex_flush),
    .stall          (stall),
    .mem_valid      (mem_valid),
    .mem_alu_result (mem_alu_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write)
  );

  // Free-running pipeline clock
  always #5 clk = ~clk;

  // Architectural meaning of each operation, written as plain arithmetic
  function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    longint unsigned prod;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: begin
        if (MulEn) begin
          prod = longint'(a) * longint'(b);
          return prod[31:0];
        end
        return a + b;
      end
      default: begin
        case (f3)
          3'd0: return a + b;
          3'd1: return a << (b % 32);
          3'd2: return (sa < sb) ? 32'd1 : 32'd0;
          3'd3: return (a < b) ? 32'd1 : 32'd0;
          3'd4: return a ^ b;
          3'd5: return a >> (b % 32);
          3'd6: return a | b;
          default: return a & b;
        endcase
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, mem_valid}, {31'd0, expValid});
    checkOutput({tag, "_result"}, mem_alu_result, expResult);
    checkOutput({tag, "_store"}, mem_store_data, expStore);
    checkOutput({tag, "_rd"}, {27'd0, mem_rd}, {27'd0, expRd});
    checkOutput({tag, "_regwrite"}, {31'd0, mem_reg_write}, {31'd0, expRw});
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic src, input logic [4:0] rd, input logic rw, input logic fl);
    ex_valid      = v;
    ex_alu_op     = op;
    ex_funct3     = f3;
    ex_read_data1 = a;
    ex_read_data2 = b;
    ex_imm_ext    = imm;
    ex_alu_src    = src;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    expValid  = 1'b0;
    expResult = 32'd0;
    expStore  = 32'd0;
    expRd     = 5'd0;
    expRw     = 1'b0;
  endtask

  // One single-cycle instruction: stall must stay low, result appears after one edge
  task automatic issueSingle(input string tag, input logic v, input logic [1:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                             input logic src, input logic [4:0] rd, input logic rw, input logic fl);
    applyStimulus(v, op, f3, a, b, imm, src, rd, rw, fl);
    #1;
    checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
    tick();
    if (v && !fl) begin
      expValid  = 1'b1;
      expResult = refAlu(op, f3, a, src ? imm : b);
      expStore  = b;
      expRd     = rd;
      expRw     = rw && (rd != 5'd0);
    end else begin
      expValid = 1'b0;
      expRw    = 1'b0;
    end
    checkAll(tag);
  endtask

`ifdef EX_MUL_EN
  // One multiply held upstream while stalled; counts stall cycles and commit pulses
  task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int stallCycles;
    int pulses;
    logic sawStall;
    logic [31:0] res;
    stallCycles = 0;
    pulses = 0;
    res = 32'd0;
    applyStimulus(1'b1, 2'd3, 3'd0, a, b, 32'd0, 1'b0, rd, 1'b1, 1'b0);
    for (int c = 0; c < 50; c++) begin
      #1;
      sawStall = stall;
      tick();
      if (mem_valid) begin
        pulses++;
        res = mem_alu_result;
      end
      if (sawStall) stallCycles++;
      else break;
    end
    checkOutput({tag, "_stallcycles"}, stallCycles, 32'd33);
    checkOutput({tag, "_pulses"}, pulses, 32'd1);
    checkOutput({tag, "_product"}, res, refAlu(2'd3, 3'd0, a, b));
    expValid  = 1'b1;
    expResult = refAlu(2'd3, 3'd0, a, b);
    expStore  = b;
    expRd     = rd;
    expRw     = (rd != 5'd0);
    checkAll(tag);
  endtask
`endif

  initial begin
    logic [1:0]  rOp;
    logic [2:0]  rF3;
    logic [31:0] rA, rB, rImm;
    logic        rSrc, rRw, rV, rFl;
    logic [4:0]  rRd;

    $display("[TB] start, MulEn=%0d", MulEn);
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    clearModel();
    tick();
    tick();
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkAll("reset");
    @(negedge clk);
    reset = 1'b0;

    // Immediate ADD
    issueSingle("add_imm", 1'b1, 2'd0, 3'd0, 32'd5, 32'd99, 32'd7, 1'b1, 5'd3, 1'b1, 1'b0);
    // SUB with register operand
    issueSingle("sub_reg", 1'b1, 2'd1, 3'd0, 32'd10, 32'd13, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    // Signed / unsigned compare boundaries and shift using only B[4:0]
    issueSingle("slt", 1'b1, 2'd2, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    issueSingle("sltu", 1'b1, 2'd2, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    issueSingle("sll", 1'b1, 2'd2, 3'd1, 32'd1, 32'h23, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    // rd=0 suppresses writeback but the entry is still valid
    issueSingle("rd_zero", 1'b1, 2'd0, 3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    // Bubbles: invalid slot and flushed slot hold the data fields
    issueSingle("bubble", 1'b0, 2'd0, 3'd0, 32'd77, 32'd88, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    issueSingle("flushed", 1'b1, 2'd0, 3'd0, 32'd77, 32'd88, 32'd0, 1'b0, 5'd9, 1'b1, 1'b1);

`ifdef EX_MUL_EN
    // Long multiply held during stall, then a back-to-back second multiply
    runMul("mul_a", 32'h0001_0000, 32'h0001_0001, 5'd8);
    runMul("mul_b", $urandom, $urandom, 5'd12);
    applyStimulus(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("mul_norestart_stall", {31'd0, stall}, 32'd0);
    tick();
    expValid = 1'b0;
    expRw    = 1'b0;
    checkAll("mul_norestart");

    // Flush in the middle of a multiply
    applyStimulus(1'b1, 2'd3, 3'd0, 32'd3, 32'd4, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) tick();
    checkOutput("flush_busy_stall", {31'd0, stall}, 32'd1);
    ex_flush = 1'b1;
    tick();
    expValid = 1'b0;
    expRw    = 1'b0;
    checkAll("flush_bubble");
    issueSingle("after_flush", 1'b1, 2'd0, 3'd0, 32'd20, 32'd22, 32'd0, 1'b0, 5'd11, 1'b1, 1'b0);

    // Flush on the very cycle a multiply would start
    applyStimulus(1'b1, 2'd3, 3'd0, 32'd3, 32'd4, 32'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    #1;
    checkOutput("flush_start_stall", {31'd0, stall}, 32'd0);
    tick();
    expValid = 1'b0;
    expRw    = 1'b0;
    checkAll("flush_start");

    // Reset in the middle of a multiply
    applyStimulus(1'b1, 2'd3, 3'd0, 32'd9, 32'd9, 32'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    #1;
    checkOutput("pre_reset_stall", {31'd0, stall}, 32'd1);
`else
    // Without the multiplier alu_op=11 is a plain ADD
    issueSingle("op11_add", 1'b1, 2'd3, 3'd0, 32'h0001_0000, 32'h0001_0001, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 3'd0, 32'd9, 32'd9, 32'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    #2;
`endif
    reset = 1'b1;
    #1;
    clearModel();
    checkOutput("async_reset_stall", {31'd0, stall}, 32'd0);
    checkAll("async_reset");
    @(negedge clk);
    reset = 1'b0;
    issueSingle("post_reset_add", 1'b1, 2'd0, 3'd0, 32'd2, 32'd2, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0);

    // Randomized single-cycle traffic against the model
    for (int i = 0; i < 40; i++) begin
      rOp  = 2'($urandom_range(0, MulEn ? 2 : 3));
      rF3  = 3'($urandom_range(0, 7));
      rA   = $urandom;
      rB   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rImm = $urandom;
      rSrc = 1'($urandom_range(0, 1));
      rRd  = 5'($urandom_range(0, 31));
      rRw  = 1'($urandom_range(0, 1));
      rV   = ($urandom_range(0, 7) != 0);
      rFl  = ($urandom_range(0, 7) == 0);
      issueSingle("rand", rV, rOp, rF3, rA, rB, rImm, rSrc, rRd, rRw, rFl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
